// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped instruction cache plus its miss/fill FSM.
// Hits return the instruction combinationally. A miss issues a single-cycle
// ldp request and waits for ldr, then writes the returned line.
// Optional feature macro: ICACHE_STATS_EN adds the hit_cnt and miss_cnt outputs.
//
// state | meaning
// IDLE  | lookup; a hit returns instr, a miss latches the line address
// REQ   | ldp high for exactly one cycle with ldAddr
// WAIT  | waiting for ldr; the fill is written when ldr arrives
module icache_fill_ctrl #(
  parameter int ICLLEN = 128,
  parameter int NLINES = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              stall,
  output logic              ldp,
  output logic [ADDR_W-1:0] ldAddr,
  input  logic              ldr,
  input  logic [ICLLEN-1:0] ldData
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IW = $clog2(NLINES);
  localparam int TW = ADDR_W - 4 - IW;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [ICLLEN-1:0] data_q [NLINES];
  logic [TW-1:0]     tag_q  [NLINES];
  logic [NLINES-1:0] valid_q;
  logic              drop_q;
  logic [ADDR_W-1:0] miss_addr_q;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    off;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          miss;
  logic          fill;
  logic          unused_pc;

  assign idx       = pc[4 +: IW];
  assign tag       = pc[ADDR_W-1 -: TW];
  assign off       = pc[3:2];
  assign fill_idx  = miss_addr_q[4 +: IW];
  assign fill_tag  = miss_addr_q[ADDR_W-1 -: TW];
  assign unused_pc = ^pc[1:0];

  assign hit  = (state_q == IDLE) && pc_valid && valid_q[idx] && (tag_q[idx] == tag);
  assign miss = (state_q == IDLE) && pc_valid && !hit;
  assign fill = (state_q == WAIT) && ldr;

  // Next-state logic and outputs; outputs are held at zero while rst is low.
  always_comb begin
    state_d     = state_q;
    instr_valid = 1'b0;
    instr       = '0;
    stall       = 1'b0;
    ldp         = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          instr_valid = 1'b1;
          instr       = data_q[idx][{off, 5'b0} +: 32];
        end
        if (miss) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        ldp     = 1'b1;
        stall   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (ldr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      instr_valid = 1'b0;
      instr       = '0;
      stall       = 1'b0;
      ldp         = 1'b0;
    end
  end

  assign ldAddr = miss_addr_q;

  // State, valid bits, drop flag and latched miss address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      drop_q      <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) miss_addr_q <= {pc[ADDR_W-1:4], 4'b0};
      // Flush beats a coincident fill, so the line stays invalid.
      if (flush)                valid_q           <= '0;
      else if (fill && !drop_q) valid_q[fill_idx] <= 1'b1;
      if (state_q == WAIT) begin
        if (ldr)        drop_q <= 1'b0;
        else if (flush) drop_q <= 1'b1;
      end
    end
  end

  // Line data and tag storage; contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[fill_idx] <= ldData;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  // Free-running hit/miss statistics, unaffected by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed testbench for icache_fill_ctrl with a scoreboard of expected hits.
module tb_icache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         pc_valid;
  logic [31:0]  pc;
  logic         flush;
  logic         instr_valid;
  logic [31:0]  instr;
  logic         stall;
  logic         ldp;
  logic [31:0]  ldAddr;
  logic         ldr;
  logic [127:0] ldData;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  icache_fill_ctrl dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .flush(flush),
    .instr_valid(instr_valid), .instr(instr), .stall(stall),
    .ldp(ldp), .ldAddr(ldAddr), .ldr(ldr), .ldData(ldData)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00108093;
      32'h4:   return 32'h021081B3;
      32'h8:   return 32'h003100B3;
      32'hC:   return 32'h001080A3;
      default: return a ^ 32'hC0DE_5A00;
    endcase
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    return {mem_word(base + 32'd12), mem_word(base + 32'd8),
            mem_word(base + 32'd4), mem_word(base)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects a hit on address a this cycle, then advances one cycle.
  task automatic fetch_hit(input logic [31:0] a);
    logic [31:0] e;
    pc_valid = 1'b1;
    pc       = a;
    exp_q.push_back(mem_word({a[31:2], 2'b00}));
    #1;
    chk("hit_stall", stall, 0);
    chk("hit_ldp", ldp, 0);
    chk("hit_valid", instr_valid, 1);
    e = exp_q.pop_front();
    chk("hit_instr", instr, e);
    tick();
  endtask

  // Full miss sequence; with flush_wait the fill is dropped and no hit follows.
  task automatic fetch_miss(input logic [31:0] a, input bit flush_wait);
    logic [31:0] base;
    base     = {a[31:4], 4'b0};
    pc_valid = 1'b1;
    pc       = a;
    #1;
    chk("miss_stall", stall, 1);
    chk("miss_noinstr", instr_valid, 0);
    chk("miss_noldp", ldp, 0);
    tick();
    chk("req_ldp", ldp, 1);
    chk("req_addr", ldAddr, base);
    chk("req_stall", stall, 1);
    tick();
    chk("wait_ldp", ldp, 0);
    chk("wait_stall", stall, 1);
    chk("wait_addr", ldAddr, base);
    if (flush_wait) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("wait_ldp_hold", ldp, 0);
      chk("wait_stall_hold", stall, 1);
    end
    ldr    = 1'b1;
    ldData = line_of(base);
    tick();
    ldr    = 1'b0;
    ldData = '0;
    if (!flush_wait) fetch_hit(a);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    pc_valid = 1'b1;
    pc       = 32'h0;
    flush    = 1'b0;
    ldr      = 1'b0;
    ldData   = '0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_ldp", ldp, 0);
    chk("rst_ldaddr", ldAddr, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    tick();
    tick();
    rst = 1'b1;

    // Cold miss on line 0, then the remaining words hit.
    fetch_miss(32'h0, 1'b0);
    fetch_hit(32'h4);
`ifdef ICACHE_STATS_EN
    chk("stat_hit_a", hit_cnt, 2);
    chk("stat_miss_a", miss_cnt, 1);
`endif
    fetch_hit(32'h8);
    fetch_hit(32'hC);

    // Same index, different tag: replaces line, then 0x0 misses again.
    fetch_miss(32'h40, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("stat_hit_b", hit_cnt, 5);
    chk("stat_miss_b", miss_cnt, 2);
`endif
    fetch_miss(32'h0, 1'b0);
    fetch_hit(32'h8);

    // No request while fetch is idle.
    pc_valid = 1'b0;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_ivalid", instr_valid, 0);
    tick();

    // Flush during WAIT drops the fill; 0x10 misses again.
    fetch_miss(32'h10, 1'b1);
    fetch_miss(32'h10, 1'b0);
    fetch_hit(32'h14);

    // Flush in IDLE: same-cycle lookup still hits, next one misses.
    flush = 1'b1;
    fetch_hit(32'h18);
    flush = 1'b0;
    fetch_miss(32'h1C, 1'b0);

    // Reset mid-WAIT abandons the miss.
    pc_valid = 1'b1;
    pc       = 32'h20;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_stall", stall, 0);
    chk("rstw_ldp", ldp, 0);
    chk("rstw_ldaddr", ldAddr, 0);
    pc_valid = 1'b0;
    tick();
    rst = 1'b1;
    // Stray ldr in IDLE must not write anything.
    ldr    = 1'b1;
    ldData = {4{32'hDEADBEEF}};
    tick();
    ldr    = 1'b0;
    ldData = '0;
    fetch_miss(32'h20, 1'b0);
    fetch_miss(32'h4, 1'b0);
    pc_valid = 1'b0;
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Direct-mapped instruction cache with its miss/fill controller.
- The fetch stage presents a PC; hits return the 32-bit instruction combinationally. On a miss the block acts as the requesting (consumer) end of the data_bus load protocol: it pulses ldp, waits for ldr, and captures the 128-bit ldData line.
- Sits between the fetch stage and main memory.

Parameters:
- ICLLEN, 128, cache line width in bits (four 32-bit instructions).
- NLINES, 4, number of lines (power of 2, >= 2).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- pc_valid  in  1  fetch request valid
- pc  in  ADDR_W  fetch byte address; bits [1:0] ignored
- flush  in  1  invalidate all lines (fence.i)
- instr_valid  out  1  instr holds a valid hit result this cycle
- instr  out  32  fetched instruction
- stall  out  1  fetch must hold pc
- ldp  out  1  load request pulse to memory (data_bus)
- ldAddr  out  ADDR_W  line-aligned request address
- ldr  in  1  load response valid (data_bus)
- ldData  in  ICLLEN  returned line

Behaviour:
- Reset: the asynchronous assertion of rst (low) forces the following, regardless of clock:
  - state=IDLE, all valid bits=0, ldp=0, ldAddr=0.
  - instr_valid=0, instr=0, stall=0, drop flag=0.
- Reset asserted mid-miss abandons the miss. An ldr arriving after reset release while in IDLE is ignored.
- Address split:
  - word offset = pc[3:2]
  - index = pc[4 +: log2(NLINES)]
  - tag = pc[ADDR_W-1 : 4+log2(NLINES)]
- Storage: flop arrays data[NLINES], tag[NLINES], valid[NLINES].
- States: IDLE, REQ, WAIT.
- IDLE:
  - Hit (pc_valid, valid[idx], tag match): instr_valid=1 and instr=word[offset] in the same cycle; stall=0.
  - Miss (pc_valid, no hit): stall=1 combinationally, latch miss address {pc[ADDR_W-1:4],4'b0}, go to REQ.
  - pc_valid=0: instr_valid=0, stall=0.
- REQ:
  - ldp=1 for exactly this one cycle; ldAddr = latched miss address.
  - stall=1; go to WAIT.
  - ldp never remains high two consecutive cycles, because the responder re-serves a held request.
- WAIT:
  - stall=1, ldp=0; ldAddr holds its value.
  - On ldr=1: write ldData to data[idx], the miss tag to tag[idx], set valid[idx]=1 (unless drop), go to IDLE.
  - The following IDLE cycle re-looks up the current pc. It normally hits; it re-misses if the pc changed.
- Word order: word0 = ldData[31:0], word3 = ldData[127:96].
- Latency: with the single-cycle responder, a miss detected at cycle t sees ldp at t+1, ldr at t+2, and a hit at t+3. A hit costs 0 extra cycles.
- Flush:
  - In IDLE or REQ: all valid bits cleared at the clock edge. Lookup in that same cycle still uses the pre-flush state.
  - In WAIT: valid bits cleared and the drop flag set. The fill on ldr does not set valid; drop clears on the transition to IDLE.
- Flush coincident with ldr in WAIT: flush wins; the line is not validated.
- ldr while in IDLE or REQ: ignored, no array write.
- Replacement: a fill always overwrites the indexed line; there is no dirty state.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt [31:0] and miss_cnt [31:0], both reset to 0.
  - hit_cnt increments on each IDLE cycle with a hit.
  - miss_cnt increments on each IDLE→REQ transition.
  - Both counters wrap at 2^32 - 1 → 0 and are not cleared by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, pc=0x0 pc_valid=1; memory returns 128'h001080A3_003100B3_021081B3_00108093:
  - stall=1 for 3 cycles.
  - ldp high exactly 1 cycle with ldAddr=0x0.
  - Then instr_valid=1, instr=0x00108093.
- Same line, pc=0x4/0x8/0xC on consecutive cycles → instr 0x021081B3, 0x003100B3, 0x001080A3. No ldp, stall=0.
- pc=0x40 (same index 0, different tag) → miss, ldAddr=0x40, line replaced. Then pc=0x0 misses again.
- Assert flush for 1 cycle in WAIT during a fill of pc=0x10:
  - ldr is consumed, valid stays 0, ldp never re-pulses during WAIT.
  - The next lookup of 0x10 misses again with ldAddr=0x10.
- Pull rst low while in WAIT, then release → state IDLE, ldp=0, stall=0, all lookups miss. A stray ldr=1 in IDLE writes nothing.
- With ICACHE_STATS_EN, sequence miss, hit, hit, miss → hit_cnt=2, miss_cnt=2. A preloaded miss_cnt=0xFFFFFFFF plus one miss → 0.
